mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported, synchronous-read instruction/data memory between fetch (IF) and
//  the MEM stage of the pipeline. Grants one access per cycle, generates byte enables from
//  data_size_e, and sign/zero-extends load data. Fetch stalls are bounded by a starvation limit.
// PARAMETERS
//  ADDR_WIDTH       9  word-address width of the memory (constants::ADDR_WIDTH)
//  IF_STARVE_LIMIT  4  consecutive cycles IF may lose to DM before IF is forced to win (>=1)
// PORTS
//  clock          in   1           rising-edge clock
//  reset          in   1           asynchronous, active-high reset
//  if_req         in   1           fetch request; held with if_addr until granted
//  if_addr        in   ADDR_WIDTH  fetch word address
//  if_gnt         out  1           fetch request accepted this cycle
//  if_stall       out  1           if_req & ~if_gnt
//  if_valid       out  1           fetch data valid (cycle after if_gnt)
//  if_rdata       out  32          fetch word
//  dm_req         in   1           data request; held with dm_* until granted
//  dm_we          in   1           1 = store, 0 = load
//  dm_size        in   3           data_size_e (BYTE_S/BYTE_U/HALF_S/HALF_U/WORD)
//  dm_addr        in   ADDR_WIDTH+2 byte address; [1:0] = lane offset
//  dm_wdata       in   32          store data, right-aligned
//  dm_gnt         out  1           data request accepted this cycle
//  dm_stall       out  1           dm_req & ~dm_gnt
//  dm_valid       out  1           load data / store ack (cycle after dm_gnt)
//  dm_err         out  1           with dm_valid: access was misaligned or size UNDEF
//  dm_rdata       out  32          extended load data (0 for stores and errors)
//  mem_en         out  1           memory access strobe
//  mem_we         out  4           byte write enables
//  mem_addr       out  ADDR_WIDTH  memory word address
//  mem_wdata      out  32          lane-replicated store data
//  mem_rdata      in   32          memory read data, valid cycle after mem_en
// BEHAVIOUR
//  - Grants combinational from requests + state; mem_* combinational mux of granted port.
//  - At most one of if_gnt/dm_gnt per cycle. DM wins by default (older instruction).
//  - starve_cnt: +1 each cycle if_req=1 and dm_gnt=1; cleared when if_gnt=1 or if_req=0;
//    saturates at IF_STARVE_LIMIT. Both requesting and starve_cnt==IF_STARVE_LIMIT -> IF wins.
//  - Latency 1: grant at cycle t -> *_valid=1 at t+1 for exactly one cycle. Requester
//    advances on the edge ending t; a new request at t+1 may be granted at t+1 (back-to-back).
//  - Response tracking register: owner {NONE,IF,DM}, load size, lane offset, err.
//  - Byte enables (off=dm_addr[1:0]): BYTE 0001<<off; HALF 0011<<off; WORD 1111.
//    mem_wdata: byte replicated x4, half x2, word as-is. Loads: mem_we=0000.
//  - Misaligned (HALF with off[0]=1, WORD with off!=0) or size UNDEF: dm_gnt=1, mem_en=0,
//    next cycle dm_valid=1, dm_err=1, dm_rdata=0. Counts as a DM grant for starvation.
//  - Load extract: lane selected by registered offset; BYTE_S/HALF_S sign-extend,
//    BYTE_U/HALF_U zero-extend, WORD pass-through. if_rdata = mem_rdata unmodified.
//  - No requests: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
//  - Reset (async, any time): owner=NONE, starve_cnt=0, if_valid=dm_valid=dm_err=0,
//    rdata outputs 0; while reset=1 all grants and mem_en forced 0. An access in flight
//    at reset never produces a valid.
// TESTING
//  1 Reset mid-access: if_gnt at t, reset at t+0.5 -> if_valid stays 0, mem_en=0 during reset.
//  2 Load: mem word 0x8000_80F0, dm LB addr off=0 -> dm_rdata 0xFFFF_FFF0; LBU -> 0x0000_00F0;
//    LH off=2 -> 0xFFFF_8000; LHU off=2 -> 0x0000_8000; LW -> 0x8000_80F0, all 1-cycle latency.
//  3 Store: SB off=3 wdata 0xAB -> mem_we=1000, mem_wdata 0xABAB_ABAB; SH off=2 -> 1100;
//    dm_valid next cycle, dm_err=0, dm_rdata=0.
//  4 Contention: if_req and dm_req held high 8 cycles (DM re-requesting) -> grant pattern
//    DM,DM,DM,DM,IF,DM,DM,DM; if_stall high exactly on DM-grant cycles.
//  5 Misaligned: LW off=1 and LH off=3 -> mem_en=0, dm_valid=1 & dm_err=1 next cycle,
//    dm_rdata=0; size UNDEF likewise.
//  6 Back-to-back fetch, no DM: if_addr 0,1,2,3 granted on 4 consecutive cycles, if_valid
//    high 4 consecutive cycles with matching words, if_stall never high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported synchronous-read memory between instruction fetch and the data stage,
// with byte-lane steering for stores, load extension, and a bounded fetch starvation window.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 9,
    parameter int unsigned IF_STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_stall,
    output logic                  if_valid,
    output logic [31:0]           if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [2:0]            dm_size,
    input  logic [ADDR_WIDTH+1:0] dm_addr,
    input  logic [31:0]           dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_stall,
    output logic                  dm_valid,
    output logic                  dm_err,
    output logic [31:0]           dm_rdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int unsigned CNT_W = $clog2(IF_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IF_STARVE_LIMIT);

    // data_size_e encoding; every other code is UNDEF
    localparam logic [2:0] SIZE_BYTE_S = 3'd0;
    localparam logic [2:0] SIZE_HALF_S = 3'd1;
    localparam logic [2:0] SIZE_WORD   = 3'd2;
    localparam logic [2:0] SIZE_BYTE_U = 3'd4;
    localparam logic [2:0] SIZE_HALF_U = 3'd5;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;

    logic [1:0]       owner_q, owner_d;
    logic [2:0]       size_q, size_d;
    logic [1:0]       off_q, off_d;
    logic             load_q, load_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic       force_if;
    logic       is_byte, is_half, is_word;
    logic       dm_bad;
    logic [1:0] dm_off;
    logic [3:0] dm_be;
    logic [31:0] dm_wrep;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;

    // DM wins unless fetch has been starved for the full window
    assign force_if = if_req & dm_req & (starve_q == CNT_MAX);
    assign if_gnt   = ~reset & if_req & (~dm_req | force_if);
    assign dm_gnt   = ~reset & dm_req & ~force_if;
    assign if_stall = if_req & ~if_gnt;
    assign dm_stall = dm_req & ~dm_gnt;

    assign dm_off  = dm_addr[1:0];
    assign is_byte = (dm_size == SIZE_BYTE_S) | (dm_size == SIZE_BYTE_U);
    assign is_half = (dm_size == SIZE_HALF_S) | (dm_size == SIZE_HALF_U);
    assign is_word = (dm_size == SIZE_WORD);
    assign dm_bad  = ~(is_byte | is_half | is_word) | (is_half & dm_off[0]) |
                     (is_word & (dm_off != 2'd0));

    // Byte enables and lane-replicated store data
    always_comb begin
        dm_be   = 4'b1111;
        dm_wrep = dm_wdata;
        if (is_byte) begin
            dm_be   = 4'b0001 << dm_off;
            dm_wrep = {4{dm_wdata[7:0]}};
        end else if (is_half) begin
            dm_be   = 4'b0011 << dm_off;
            dm_wrep = {2{dm_wdata[15:0]}};
        end
    end

    // Memory port mux; a faulting DM access is granted but never reaches memory
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (dm_gnt && !dm_bad) begin
            mem_en   = 1'b1;
            mem_addr = dm_addr[ADDR_WIDTH+1:2];
            if (dm_we) begin
                mem_we    = dm_be;
                mem_wdata = dm_wrep;
            end
        end
    end

    // Next response-tracking and starvation state
    always_comb begin
        owner_d  = OWN_NONE;
        size_d   = size_q;
        off_d    = off_q;
        load_d   = 1'b0;
        err_d    = 1'b0;
        starve_d = starve_q;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (dm_gnt) begin
            owner_d = OWN_DM;
            size_d  = dm_size;
            off_d   = dm_off;
            load_d  = ~dm_we;
            err_d   = dm_bad;
        end
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (dm_gnt && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            size_q   <= 3'd0;
            off_q    <= 2'd0;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            size_q   <= size_d;
            off_q    <= off_d;
            load_q   <= load_d;
            err_q    <= err_d;
            starve_q <= starve_d;
        end
    end

    // Load lane extraction from the offset captured at grant time
    always_comb begin
        byte_lane = 8'(mem_rdata >> {off_q, 3'b000});
        half_lane = 16'(mem_rdata >> {off_q[1], 4'b0000});
        case (size_q)
            SIZE_BYTE_S: load_ext = {{24{byte_lane[7]}}, byte_lane};
            SIZE_BYTE_U: load_ext = {24'd0, byte_lane};
            SIZE_HALF_S: load_ext = {{16{half_lane[15]}}, half_lane};
            SIZE_HALF_U: load_ext = {16'd0, half_lane};
            default:     load_ext = mem_rdata;
        endcase
    end

    assign if_valid = (owner_q == OWN_IF);
    assign dm_valid = (owner_q == OWN_DM);
    assign dm_err   = dm_valid & err_q;
    assign if_rdata = if_valid ? mem_rdata : 32'd0;
    assign dm_rdata = (dm_valid && load_q && !err_q) ? load_ext : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural synchronous-read memory.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 9;

    localparam logic [2:0] SZ_BS = 3'd0;
    localparam logic [2:0] SZ_HS = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_UD = 3'd3;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    logic          clock, reset;
    logic          if_req, if_gnt, if_stall, if_valid;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_stall, dm_valid, dm_err;
    logic [2:0]    dm_size;
    logic [AW+1:0] dm_addr;
    logic [31:0]   dm_wdata, dm_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    mem_port_arbiter #(.ADDR_WIDTH(AW), .IF_STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_stall(dm_stall), .dm_valid(dm_valid),
        .dm_err(dm_err), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memory with byte writes; contents re-seeded while reset is high
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'd0;
            mem[0]    <= 32'h1111_0000;
            mem[1]    <= 32'h2222_0001;
            mem[2]    <= 32'h3333_0002;
            mem[3]    <= 32'h4444_0003;
            mem[16]   <= 32'h8000_80F0;
            mem_rdata <= 32'd0;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    task automatic dm_drive(input logic we, input logic [2:0] size,
                            input logic [AW+1:0] addr, input logic [31:0] wdata);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_size  = size;
        dm_addr  = addr;
        dm_wdata = wdata;
    endtask

    task automatic test_reset;
        @(negedge clock);
        if_req = 1'b1; if_addr = 9'd2; dm_req = 1'b1; dm_size = SZ_W; dm_addr = 11'd64;
        #1;
        checks++; if ({if_gnt, dm_gnt, mem_en} !== 3'b000) begin
            errors++; $display("FAIL reset_grants got %b exp 000", {if_gnt, dm_gnt, mem_en});
        end
        checks++; if ({if_valid, dm_valid, dm_err} !== 3'b000) begin
            errors++; $display("FAIL reset_valids got %b exp 000", {if_valid, dm_valid, dm_err});
        end
        checks++; if ((if_rdata !== 32'd0) || (dm_rdata !== 32'd0)) begin
            errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", if_rdata, dm_rdata);
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL idle_mem got en=%b we=%b a=%h d=%h exp all 0",
                               mem_en, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset_mid_access;
        @(negedge clock);
        if_req = 1'b1; if_addr = 9'd1;
        #1;
        checks++; if (if_gnt !== 1'b1) begin
            errors++; $display("FAIL mid_reset_gnt got %b exp 1", if_gnt);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        checks++; if ({if_valid, mem_en, if_gnt} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_in_reset got valid/en/gnt=%b exp 000",
                               {if_valid, mem_en, if_gnt});
        end
        @(negedge clock);
        if_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_after got if_valid=%b exp 0", if_valid);
        end
        @(negedge clock);
        #1;
        checks++; if (if_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_late got if_valid=%b exp 0", if_valid);
        end
    endtask

    task automatic test_load;
        logic [2:0]    sz  [5];
        logic [AW+1:0] ad  [5];
        logic [31:0]   exp [5];
        sz[0] = SZ_BS; ad[0] = 11'd64; exp[0] = 32'hFFFF_FFF0;
        sz[1] = SZ_BU; ad[1] = 11'd64; exp[1] = 32'h0000_00F0;
        sz[2] = SZ_HS; ad[2] = 11'd66; exp[2] = 32'hFFFF_8000;
        sz[3] = SZ_HU; ad[3] = 11'd66; exp[3] = 32'h0000_8000;
        sz[4] = SZ_W;  ad[4] = 11'd64; exp[4] = 32'h8000_80F0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            dm_drive(1'b0, sz[k], ad[k], 32'hDEAD_BEEF);
            #1;
            checks++; if ({dm_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 4'b0000, 9'd16}) begin
                errors++; $display("FAIL load_issue[%0d] got gnt=%b en=%b we=%b a=%h exp 1 1 0000 010",
                                   k, dm_gnt, mem_en, mem_we, mem_addr);
            end
            @(negedge clock);
            dm_req = 1'b0;
            #1;
            checks++; if ({dm_valid, dm_err, dm_rdata} !== {1'b1, 1'b0, exp[k]}) begin
                errors++; $display("FAIL load_data[%0d] got v=%b e=%b d=%h exp 1 0 %h",
                                   k, dm_valid, dm_err, dm_rdata, exp[k]);
            end
        end
    endtask

    task automatic test_store;
        @(negedge clock);
        dm_drive(1'b1, SZ_BS, 11'd83, 32'h0000_00AB);
        #1;
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b1000, 9'd20, 32'hABAB_ABAB}) begin
            errors++; $display("FAIL store_sb got en=%b we=%b a=%h d=%h exp 1 1000 014 ababab ab",
                               mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clock);
        dm_drive(1'b1, SZ_HS, 11'd82, 32'h0000_1234);
        #1;
        checks++; if ({dm_valid, dm_err, dm_rdata} !== {1'b1, 1'b0, 32'd0}) begin
            errors++; $display("FAIL store_ack got v=%b e=%b d=%h exp 1 0 0", dm_valid, dm_err, dm_rdata);
        end
        checks++; if ({mem_en, mem_we, mem_wdata} !== {1'b1, 4'b1100, 32'h1234_1234}) begin
            errors++; $display("FAIL store_sh got en=%b we=%b d=%h exp 1 1100 12341234",
                               mem_en, mem_we, mem_wdata);
        end
        @(negedge clock);
        dm_drive(1'b0, SZ_W, 11'd80, 32'd0);
        @(negedge clock);
        dm_req = 1'b0;
        #1;
        checks++; if (dm_rdata !== 32'h1234_0000) begin
            errors++; $display("FAIL store_readback got %h exp 12340000", dm_rdata);
        end
    endtask

    task automatic test_contention;
        logic exp_if [8];
        for (int c = 0; c < 8; c++) exp_if[c] = (c == 4);
        @(negedge clock);
        if_req = 1'b1; if_addr = 9'd7;
        dm_drive(1'b0, SZ_W, 11'd64, 32'd0);
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if ({if_gnt, dm_gnt, if_stall, dm_stall} !==
                          {exp_if[c], ~exp_if[c], ~exp_if[c], exp_if[c]}) begin
                errors++; $display("FAIL contention[%0d] got ig/dg/is/ds=%b%b%b%b exp if_win=%b",
                                   c, if_gnt, dm_gnt, if_stall, dm_stall, exp_if[c]);
            end
            @(negedge clock);
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_misaligned;
        logic [2:0]    sz [3];
        logic [AW+1:0] ad [3];
        sz[0] = SZ_W;  ad[0] = 11'd65;
        sz[1] = SZ_HS; ad[1] = 11'd67;
        sz[2] = SZ_UD; ad[2] = 11'd64;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            dm_drive(1'b0, sz[k], ad[k], 32'd0);
            #1;
            checks++; if ({dm_gnt, mem_en} !== 2'b10) begin
                errors++; $display("FAIL misalign_issue[%0d] got gnt=%b en=%b exp 1 0", k, dm_gnt, mem_en);
            end
            @(negedge clock);
            dm_req = 1'b0;
            #1;
            checks++; if ({dm_valid, dm_err, dm_rdata} !== {1'b1, 1'b1, 32'd0}) begin
                errors++; $display("FAIL misalign_resp[%0d] got v=%b e=%b d=%h exp 1 1 0",
                                   k, dm_valid, dm_err, dm_rdata);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [4];
        words[0] = 32'h1111_0000; words[1] = 32'h2222_0001;
        words[2] = 32'h3333_0002; words[3] = 32'h4444_0003;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i < 4) begin
                if_req = 1'b1; if_addr = AW'(i);
            end else begin
                if_req = 1'b0;
            end
            #1;
            if (i < 4) begin
                checks++; if ({if_gnt, if_stall, mem_addr} !== {1'b1, 1'b0, AW'(i)}) begin
                    errors++; $display("FAIL b2b_gnt[%0d] got gnt=%b stall=%b a=%h", i, if_gnt, if_stall, mem_addr);
                end
            end
            if (i > 0) begin
                checks++; if ({if_valid, if_rdata} !== {1'b1, words[i-1]}) begin
                    errors++; $display("FAIL b2b_data[%0d] got v=%b d=%h exp 1 %h",
                                       i, if_valid, if_rdata, words[i-1]);
                end
            end
        end
        @(negedge clock);
        #1;
        checks++; if (if_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_end got if_valid=%b exp 0", if_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 3'd0; dm_addr = '0; dm_wdata = 32'd0;
        repeat (3) @(negedge clock);
        test_reset;
        test_reset_mid_access;
        test_load;
        test_store;
        test_contention;
        test_misaligned;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
